// File: rtl/bricks_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bricks_pkg
// Description : Shared definitions for the brick game playfield: grid
//               geometry, ball direction encoding and the playfield FSM
//               state type.
// Revision    : 1.0 - initial release
// ============================================================================
package bricks_pkg;

    // Grid geometry
    localparam int ROWS       = 12;
    localparam int COLS       = 16;
    localparam int PADDLE_ROW = 11;

    // Ball direction. UP = row-1, DOWN = row+1, RIGHT = col-1, LEFT = col+1.
    typedef enum logic [1:0] {
        DIR_UP_RIGHT   = 2'b00,
        DIR_UP_LEFT    = 2'b01,
        DIR_DOWN_RIGHT = 2'b10,
        DIR_DOWN_LEFT  = 2'b11
    } dir_t;

    // Playfield sequencing
    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_PLAY = 3'd1,
        ST_MISS = 3'd2,
        ST_WIN  = 3'd3,
        ST_OVER = 3'd4
    } field_state_t;

endpackage
`default_nettype wire

// File: rtl/brick_hit_detect.sv
`default_nettype none
// ============================================================================
// Module      : brick_hit_detect
// Description : Combinational collision finder. From the ball position and
//               direction it locates the vertical (V), horizontal (H) and
//               diagonal (D) neighbour cells and returns which bricks must be
//               cleared this cycle. V/H take priority over D, mirroring the
//               bounce rule of the ball-movement block.
// Ports       : i_row, i_col  - ball position
//               i_dir         - ball direction
//               i_bricks      - brick region, bit (r-1)*16+c for rows 1..N
//               o_clear_mask  - bricks to clear, same layout as i_bricks
//               o_hit_count   - number of bits set in o_clear_mask (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module brick_hit_detect
    import bricks_pkg::*;
#(
    parameter int BRICK_ROWS = 4
) (
    input  logic [3:0]                 i_row,
    input  logic [3:0]                 i_col,
    input  dir_t                       i_dir,
    input  logic [BRICK_ROWS*COLS-1:0] i_bricks,
    output logic [BRICK_ROWS*COLS-1:0] o_clear_mask,
    output logic [1:0]                 o_hit_count
);

    localparam int         c_CELLS    = BRICK_ROWS * COLS;
    localparam int         c_IDX_W    = $clog2(c_CELLS);
    localparam logic [4:0] c_LAST_ROW = 5'(BRICK_ROWS);

    logic       w_up;
    logic       w_right;
    logic [4:0] w_row5;
    logic [4:0] w_col5;
    logic [4:0] w_vrow;
    logic [4:0] w_hcol;
    logic       w_v_hit;
    logic       w_h_hit;
    logic       w_d_hit;

    // Neighbours are formed 5 bits wide so that stepping off an edge lands
    // outside the grid (e.g. col 15+1 = 16, col 0-1 = 31) instead of wrapping.
    function automatic logic in_region(input logic [4:0] r, input logic [4:0] c);
        return (r >= 5'd1) && (r <= c_LAST_ROW) && (c < 5'(COLS));
    endfunction

    function automatic logic [c_IDX_W-1:0] cell_idx(input logic [4:0] r, input logic [4:0] c);
        return c_IDX_W'((int'(r) - 1) * COLS + int'(c));
    endfunction

    assign w_up    = (i_dir == DIR_UP_RIGHT)   || (i_dir == DIR_UP_LEFT);
    assign w_right = (i_dir == DIR_UP_RIGHT)   || (i_dir == DIR_DOWN_RIGHT);
    assign w_row5  = {1'b0, i_row};
    assign w_col5  = {1'b0, i_col};
    assign w_vrow  = w_up    ? (w_row5 - 5'd1) : (w_row5 + 5'd1);
    assign w_hcol  = w_right ? (w_col5 - 5'd1) : (w_col5 + 5'd1);

    // Index is only meaningful when in_region holds; the AND masks it otherwise.
    assign w_v_hit = in_region(w_vrow, w_col5) && i_bricks[cell_idx(w_vrow, w_col5)];
    assign w_h_hit = in_region(w_row5, w_hcol) && i_bricks[cell_idx(w_row5, w_hcol)];
    assign w_d_hit = in_region(w_vrow, w_hcol) && i_bricks[cell_idx(w_vrow, w_hcol)];

    always_comb begin
        o_clear_mask = '0;
        o_hit_count  = 2'd0;
        if (w_v_hit || w_h_hit) begin
            if (w_v_hit) begin
                o_clear_mask[cell_idx(w_vrow, w_col5)] = 1'b1;
            end
            if (w_h_hit) begin
                o_clear_mask[cell_idx(w_row5, w_hcol)] = 1'b1;
            end
            o_hit_count = {1'b0, w_v_hit} + {1'b0, w_h_hit};
        end else if (w_d_hit) begin
            o_clear_mask[cell_idx(w_vrow, w_hcol)] = 1'b1;
            o_hit_count = 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/brick_field.sv
`default_nettype none
// ============================================================================
// Module      : brick_field
// Description : Playfield owner. Holds the brick map, exports the full 12x16
//               occupancy map to the ball block, clears bricks the ball is
//               about to strike, keeps score / remaining / lives and sequences
//               level load, play, miss recovery, level clear and game over.
// Ports       : clock, reset (async, active low)
//               Ball_rowIndex/colIndex/direction - registered ball state
//               paddle_col  - leftmost paddle cell in row 11
//               new_level   - pulse, reloads bricks when level is cleared
//               data        - occupancy map, bit row*16+col
//               score, remaining, lives - game counters
//               field_ready, miss, level_clear, game_over - status
// Revision    : 1.0 - initial release
// ============================================================================
module brick_field
    import bricks_pkg::*;
#(
    parameter int BRICK_ROWS = 4,
    parameter int PADDLE_W   = 4,
    parameter int LIVES      = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3:0]           Ball_rowIndex,
    input  logic [3:0]           Ball_colIndex,
    input  logic [1:0]           Ball_direction,
    input  logic [3:0]           paddle_col,
    input  logic                 new_level,
    output logic [ROWS*COLS-1:0] data,
    output logic [7:0]           score,
    output logic [7:0]           remaining,
    output logic [1:0]           lives,
    output logic                 field_ready,
    output logic                 miss,
    output logic                 level_clear,
    output logic                 game_over
);

    localparam int         c_CELLS    = BRICK_ROWS * COLS;
    localparam logic [3:0] c_LAST_ROW = 4'(BRICK_ROWS);
    localparam logic [7:0] c_FULL     = 8'(BRICK_ROWS * COLS);
    localparam logic [1:0] c_LIVES    = 2'(LIVES);
    localparam logic [4:0] c_PAD_W    = 5'(PADDLE_W);

    field_state_t       r_state;
    logic [3:0]         r_row_cnt;
    logic [c_CELLS-1:0] r_bricks;
    logic [7:0]         r_score;
    logic [7:0]         r_remaining;
    logic [1:0]         r_lives;
    logic               r_field_ready;
    logic               r_miss;
    logic               r_level_clear;
    logic               r_game_over;

    logic [c_CELLS-1:0] w_clear_mask;
    logic [c_CELLS-1:0] w_load_mask;
    logic [1:0]         w_hit_count;
    logic [8:0]         w_score_sum;
    logic [7:0]         w_score_next;
    logic [7:0]         w_remaining_next;
    logic [COLS-1:0]    w_paddle_row;

    brick_hit_detect #(
        .BRICK_ROWS (BRICK_ROWS)
    ) u_hit_detect (
        .i_row        (Ball_rowIndex),
        .i_col        (Ball_colIndex),
        .i_dir        (dir_t'(Ball_direction)),
        .i_bricks     (r_bricks),
        .o_clear_mask (w_clear_mask),
        .o_hit_count  (w_hit_count)
    );

    // Paddle cells past column 15 simply fall off; the 5-bit sum cannot wrap.
    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_paddle
            assign w_paddle_row[gi] = ({1'b0, paddle_col} <= 5'(gi)) &&
                                      (5'(gi) < ({1'b0, paddle_col} + c_PAD_W));
        end
        for (gi = 0; gi < BRICK_ROWS; gi++) begin : g_load_mask
            assign w_load_mask[gi*COLS +: COLS] = {COLS{r_row_cnt == 4'(gi + 1)}};
        end
    endgenerate

    always_comb begin
        data = '0;
        data[COLS +: c_CELLS]          = r_bricks;
        data[PADDLE_ROW*COLS +: COLS]  = w_paddle_row;
    end

    assign w_score_sum      = {1'b0, r_score} + {7'd0, w_hit_count};
    assign w_score_next     = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
    assign w_remaining_next = r_remaining - {6'd0, w_hit_count};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_INIT;
            r_row_cnt     <= 4'd1;
            r_bricks      <= '0;
            r_score       <= 8'd0;
            r_remaining   <= 8'd0;
            r_lives       <= c_LIVES;
            r_field_ready <= 1'b0;
            r_miss        <= 1'b0;
            r_level_clear <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_miss <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_bricks <= r_bricks | w_load_mask;
                    if (r_row_cnt == c_LAST_ROW) begin
                        r_row_cnt     <= 4'd1;
                        r_remaining   <= c_FULL;
                        r_state       <= ST_PLAY;
                        r_field_ready <= 1'b1;
                    end else begin
                        r_row_cnt <= r_row_cnt + 4'd1;
                    end
                end
                ST_PLAY: begin
                    // Cleared on the same edge the ball block samples the old
                    // map, so both sides act on identical data.
                    r_bricks    <= r_bricks & ~w_clear_mask;
                    r_score     <= w_score_next;
                    r_remaining <= w_remaining_next;
                    if (w_remaining_next == 8'd0) begin
                        r_state       <= ST_WIN;
                        r_field_ready <= 1'b0;
                        r_level_clear <= 1'b1;
                    end else if (Ball_rowIndex == 4'(PADDLE_ROW)) begin
                        r_miss        <= 1'b1;
                        r_lives       <= r_lives - 2'd1;
                        r_field_ready <= 1'b0;
                        if (r_lives == 2'd1) begin
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state <= ST_MISS;
                        end
                    end
                end
                ST_MISS: begin
                    if (Ball_rowIndex != 4'(PADDLE_ROW)) begin
                        r_state       <= ST_PLAY;
                        r_field_ready <= 1'b1;
                    end
                end
                ST_WIN: begin
                    if (new_level) begin
                        r_state       <= ST_INIT;
                        r_level_clear <= 1'b0;
                    end
                end
                ST_OVER: begin
                    r_state <= ST_OVER;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign score       = r_score;
    assign remaining   = r_remaining;
    assign lives       = r_lives;
    assign field_ready = r_field_ready;
    assign miss        = r_miss;
    assign level_clear = r_level_clear;
    assign game_over   = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_brick_field.sv
`default_nettype none
// ============================================================================
// Module      : tb_brick_field
// Description : Self-checking bench for brick_field. A cell-array reference
//               model of the game rules runs alongside the DUT; directed and
//               randomized scenarios compare every output against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_brick_field;

    localparam int BR = 4;
    localparam int PW = 4;
    localparam int NL = 3;

    localparam int M_INIT = 0;
    localparam int M_PLAY = 1;
    localparam int M_MISS = 2;
    localparam int M_WIN  = 3;
    localparam int M_OVER = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   ball_row = 4'd0;
    logic [3:0]   ball_col = 4'd0;
    logic [1:0]   ball_dir = 2'd0;
    logic [3:0]   paddle_col = 4'd0;
    logic         new_level = 1'b0;
    logic [191:0] data;
    logic [7:0]   score;
    logic [7:0]   remaining;
    logic [1:0]   lives;
    logic         field_ready;
    logic         miss;
    logic         level_clear;
    logic         game_over;

    int checks = 0;
    int passes = 0;

    // Reference model state
    bit mb [12][16];
    int m_state;
    int m_rowcnt;
    int m_score;
    int m_rem;
    int m_lives;
    bit m_miss;
    int saved_score;

    always #5 clock = ~clock;

    brick_field #(
        .BRICK_ROWS (BR),
        .PADDLE_W   (PW),
        .LIVES      (NL)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .Ball_rowIndex  (ball_row),
        .Ball_colIndex  (ball_col),
        .Ball_direction (ball_dir),
        .paddle_col     (paddle_col),
        .new_level      (new_level),
        .data           (data),
        .score          (score),
        .remaining      (remaining),
        .lives          (lives),
        .field_ready    (field_ready),
        .miss           (miss),
        .level_clear    (level_clear),
        .game_over      (game_over)
    );

    function automatic bit occ(int r, int c);
        if (r < 1 || r > BR || c < 0 || c > 15) return 1'b0;
        return mb[4'(r)][4'(c)];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 16; c++)
                mb[4'(r)][4'(c)] = 1'b0;
        m_state  = M_INIT;
        m_rowcnt = 1;
        m_score  = 0;
        m_rem    = 0;
        m_lives  = NL;
        m_miss   = 1'b0;
    endtask

    task automatic model_step();
        int  r, c, dr, dc, n;
        bit  v, h, d;
        m_miss = 1'b0;
        case (m_state)
            M_INIT: begin
                for (int k = 0; k < 16; k++) mb[4'(m_rowcnt)][4'(k)] = 1'b1;
                if (m_rowcnt == BR) begin
                    m_rem = 16 * BR; m_rowcnt = 1; m_state = M_PLAY;
                end else begin
                    m_rowcnt++;
                end
            end
            M_PLAY: begin
                r  = int'(ball_row);
                c  = int'(ball_col);
                dr = ball_dir[1] ? 1 : -1;   // DOWN : UP
                dc = ball_dir[0] ? 1 : -1;   // LEFT : RIGHT
                v  = occ(r + dr, c);
                h  = occ(r, c + dc);
                d  = occ(r + dr, c + dc);
                n  = 0;
                if (v || h) begin
                    if (v) begin mb[4'(r + dr)][4'(c)] = 1'b0; n++; end
                    if (h) begin mb[4'(r)][4'(c + dc)] = 1'b0; n++; end
                end else if (d) begin
                    mb[4'(r + dr)][4'(c + dc)] = 1'b0; n++;
                end
                m_score = (m_score + n > 255) ? 255 : m_score + n;
                m_rem   = m_rem - n;
                if (m_rem == 0) begin
                    m_state = M_WIN;
                end else if (r == 11) begin
                    m_miss  = 1'b1;
                    m_lives = m_lives - 1;
                    m_state = (m_lives == 0) ? M_OVER : M_MISS;
                end
            end
            M_MISS: if (ball_row != 4'd11) m_state = M_PLAY;
            M_WIN:  if (new_level) m_state = M_INIT;
            default: ;
        endcase
    endtask

    function automatic logic [213:0] model_vec();
        logic [191:0] d;
        d = '0;
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 16; c++)
                if (mb[4'(r)][4'(c)]) d = d | (192'(1) << (r * 16 + c));
        for (int c = 0; c < 16; c++)
            if (c >= int'(paddle_col) && c < int'(paddle_col) + PW)
                d = d | (192'(1) << (176 + c));
        return {d, 8'(m_score), 8'(m_rem), 2'(m_lives),
                (m_state == M_PLAY), m_miss, (m_state == M_WIN), (m_state == M_OVER)};
    endfunction

    function automatic logic [213:0] dut_vec();
        return {data, score, remaining, lives, field_ready, miss, level_clear, game_over};
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic set_ball(int r, int c, logic [1:0] dir);
        ball_row = 4'(r);
        ball_col = 4'(c);
        ball_dir = dir;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        set_ball(0, 0, 2'b00);
        paddle_col = 4'd6;
        repeat (3) @(posedge clock);
        #1;
        model_reset();
        if (dut_vec() !== model_vec()) $display("FAIL reset_vec got=%h exp=%h", dut_vec(), model_vec());
        else passes++;
        checks++;
        if (data[175:0] !== 176'd0) $display("FAIL reset_bricks got=%h exp=0", data[175:0]);
        else passes++;
        checks++;
        reset = 1'b1;
    endtask

    task automatic test_level_load();
        for (int i = 0; i < BR - 1; i++) begin
            tick();
            if (field_ready !== 1'b0) $display("FAIL load_ready_early cyc=%0d got=%b exp=0", i, field_ready);
            else passes++;
            checks++;
        end
        tick();
        if (field_ready !== 1'b1) $display("FAIL load_ready got=%b exp=1", field_ready);
        else passes++;
        checks++;
        if (data[79:16] !== {64{1'b1}} || remaining !== 8'd64)
            $display("FAIL load_full got=%h rem=%0d exp=all-ones rem=64", data[79:16], remaining);
        else passes++;
        checks++;
        if (dut_vec() !== model_vec()) $display("FAIL load_vec got=%h exp=%h", dut_vec(), model_vec());
        else passes++;
        checks++;
    endtask

    task automatic test_directed_hits();
        // V hit: (5,7) UP_LEFT clears (4,7)
        set_ball(5, 7, 2'b01); tick();
        if (data[71] !== 1'b0 || data[70] !== 1'b1 || score !== 8'd1 || remaining !== 8'd63)
            $display("FAIL hit_v got b71=%b b70=%b s=%0d r=%0d exp 0 1 1 63", data[71], data[70], score, remaining);
        else passes++;
        checks++;
        // Corner, nothing reachable
        set_ball(0, 0, 2'b00); tick();
        if (score !== 8'd1 || remaining !== 8'd63)
            $display("FAIL corner_idle got s=%0d r=%0d exp 1 63", score, remaining);
        else passes++;
        checks++;
        // Pre-clear (4,8), then (5,9) UP_RIGHT clears only V (4,9)
        set_ball(5, 8, 2'b01); tick();
        set_ball(5, 9, 2'b00); tick();
        if (data[73] !== 1'b0 || score !== 8'd3 || remaining !== 8'd61)
            $display("FAIL hit_v2 got b73=%b s=%0d r=%0d exp 0 3 61", data[73], score, remaining);
        else passes++;
        checks++;
        // V and H empty: diagonal (4,10) cleared
        set_ball(5, 9, 2'b01); tick();
        if (data[74] !== 1'b0 || data[75] !== 1'b1 || score !== 8'd4)
            $display("FAIL hit_diag got b74=%b b75=%b s=%0d exp 0 1 4", data[74], data[75], score);
        else passes++;
        checks++;
        // V and H both bricks: both cleared, D kept
        set_ball(3, 3, 2'b10); tick();
        if (data[67] !== 1'b0 || data[50] !== 1'b0 || data[66] !== 1'b1 || score !== 8'd6 || remaining !== 8'd58)
            $display("FAIL hit_vh got b67=%b b50=%b b66=%b s=%0d r=%0d exp 0 0 1 6 58",
                     data[67], data[50], data[66], score, remaining);
        else passes++;
        checks++;
        // Column edges must not wrap
        set_ball(1, 15, 2'b01); tick();
        set_ball(1, 0, 2'b00); tick();
        if (data[16] !== 1'b1 || data[31] !== 1'b1 || score !== 8'd6)
            $display("FAIL edge_nowrap got b16=%b b31=%b s=%0d exp 1 1 6", data[16], data[31], score);
        else passes++;
        checks++;
        if (dut_vec() !== model_vec()) $display("FAIL directed_vec got=%h exp=%h", dut_vec(), model_vec());
        else passes++;
        checks++;
    endtask

    task automatic test_first_miss();
        set_ball(11, 5, 2'b00); tick();
        if (miss !== 1'b1 || lives !== 2'd2 || field_ready !== 1'b0)
            $display("FAIL miss_pulse got m=%b l=%0d fr=%b exp 1 2 0", miss, lives, field_ready);
        else passes++;
        checks++;
        tick();
        if (miss !== 1'b0 || field_ready !== 1'b0)
            $display("FAIL miss_hold got m=%b fr=%b exp 0 0", miss, field_ready);
        else passes++;
        checks++;
        set_ball(9, 5, 2'b00); tick();
        if (field_ready !== 1'b1) $display("FAIL miss_return got fr=%b exp 1", field_ready);
        else passes++;
        checks++;
        if (dut_vec() !== model_vec()) $display("FAIL miss_vec got=%h exp=%h", dut_vec(), model_vec());
        else passes++;
        checks++;
    endtask

    task automatic test_random_play(int cycles);
        for (int i = 0; i < cycles; i++) begin
            set_ball(int'($urandom_range(0, 10)), int'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            paddle_col = 4'($urandom_range(0, 15));
            new_level  = ($urandom_range(0, 7) == 0);
            tick();
            if (dut_vec() !== model_vec()) $display("FAIL random_vec cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            else passes++;
            checks++;
        end
        new_level = 1'b0;
    endtask

    task automatic test_level_clear();
        int tr, tc;
        for (int i = 0; i < 400 && m_state != M_WIN; i++) begin
            tr = -1; tc = 0;
            if (m_state == M_PLAY)
                for (int r = 1; r <= BR; r++)
                    for (int c = 0; c < 16; c++)
                        if (tr < 0 && mb[4'(r)][4'(c)]) begin tr = r; tc = c; end
            if (tr > 0) set_ball(tr + 1, tc, 2'b00);
            else        set_ball(0, 0, 2'b00);
            tick();
            if (dut_vec() !== model_vec()) $display("FAIL clear_vec cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            else passes++;
            checks++;
        end
        if (level_clear !== 1'b1 || field_ready !== 1'b0 || remaining !== 8'd0)
            $display("FAIL level_clear got lc=%b fr=%b r=%0d exp 1 0 0", level_clear, field_ready, remaining);
        else passes++;
        checks++;
        saved_score = m_score;
        repeat (2) tick();
        if (dut_vec() !== model_vec()) $display("FAIL win_hold got=%h exp=%h", dut_vec(), model_vec());
        else passes++;
        checks++;
    endtask

    task automatic test_reload();
        new_level = 1'b1; tick(); new_level = 1'b0;
        if (level_clear !== 1'b0 || field_ready !== 1'b0)
            $display("FAIL reload_init got lc=%b fr=%b exp 0 0", level_clear, field_ready);
        else passes++;
        checks++;
        repeat (BR) tick();
        if (remaining !== 8'd64 || field_ready !== 1'b1 || score !== 8'(saved_score))
            $display("FAIL reload_done got r=%0d fr=%b s=%0d exp 64 1 %0d", remaining, field_ready, score, saved_score);
        else passes++;
        checks++;
    endtask

    task automatic test_paddle();
        logic [3:0]  pcs [4];
        logic [15:0] exp_rows [4];
        pcs[0] = 4'd14; exp_rows[0] = 16'hC000;
        pcs[1] = 4'd0;  exp_rows[1] = 16'h000F;
        pcs[2] = 4'd12; exp_rows[2] = 16'hF000;
        pcs[3] = 4'd15; exp_rows[3] = 16'h8000;
        set_ball(0, 0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            paddle_col = pcs[i];
            tick();
            if (data[191:176] !== exp_rows[i])
                $display("FAIL paddle pc=%0d got=%h exp=%h", pcs[i], data[191:176], exp_rows[i]);
            else passes++;
            checks++;
        end
        if (dut_vec() !== model_vec()) $display("FAIL paddle_vec got=%h exp=%h", dut_vec(), model_vec());
        else passes++;
        checks++;
    endtask

    task automatic test_game_over();
        set_ball(11, 2, 2'b00); tick();
        if (lives !== 2'd1 || miss !== 1'b1) $display("FAIL miss2 got l=%0d m=%b exp 1 1", lives, miss);
        else passes++;
        checks++;
        set_ball(9, 2, 2'b00); tick();
        set_ball(11, 2, 2'b00); tick();
        if (game_over !== 1'b1 || lives !== 2'd0 || miss !== 1'b1 || field_ready !== 1'b0)
            $display("FAIL game_over got go=%b l=%0d m=%b fr=%b exp 1 0 1 0", game_over, lives, miss, field_ready);
        else passes++;
        checks++;
        new_level = 1'b1; tick(); new_level = 1'b0;
        set_ball(9, 2, 2'b00); tick();
        if (game_over !== 1'b1 || field_ready !== 1'b0)
            $display("FAIL over_sticky got go=%b fr=%b exp 1 0", game_over, field_ready);
        else passes++;
        checks++;
        if (dut_vec() !== model_vec()) $display("FAIL over_vec got=%h exp=%h", dut_vec(), model_vec());
        else passes++;
        checks++;
    endtask

    task automatic test_reset_midop();
        reset = 1'b0;
        #2;
        model_reset();
        if (dut_vec() !== model_vec()) $display("FAIL async_reset got=%h exp=%h", dut_vec(), model_vec());
        else passes++;
        checks++;
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (BR) tick();
        if (field_ready !== 1'b1 || remaining !== 8'd64 || score !== 8'd0 || lives !== 2'd3)
            $display("FAIL reset_reload got fr=%b r=%0d s=%0d l=%0d exp 1 64 0 3", field_ready, remaining, score, lives);
        else passes++;
        checks++;
        test_random_play(20);
        reset = 1'b0;
        #3;
        model_reset();
        if (dut_vec() !== model_vec()) $display("FAIL async_reset_play got=%h exp=%h", dut_vec(), model_vec());
        else passes++;
        checks++;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_level_load();
        test_directed_hits();
        test_first_miss();
        test_random_play(200);
        test_level_clear();
        test_reload();
        test_paddle();
        test_game_over();
        test_reset_midop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/brick_field.md
# brick_field

Playfield owner for the brick game. Holds the 12×16 occupancy map, drives it as the 192-bit `data` bus consumed by the ball-movement block, and watches the ball's registered position and direction. When the ball is about to strike a brick, the block clears it and updates score and remaining-brick count. It also detects missed balls, tracks lives, and sequences level load, play, level-clear and game-over.

## Interface
- `BRICK_ROWS`, default 4: number of brick rows, occupying rows 1..BRICK_ROWS; legal range 1..10.
- `PADDLE_W`, default 4: paddle width in cells; legal range 1..16.
- `LIVES`, default 3: lives loaded at reset; legal range 1..3.
- `clock`  in  1: single clock. Shared with the ball-movement block.
- `reset`  in  1: asynchronous, active-low.
- `Ball_rowIndex`  in  4: ball row, 0 = top.
- `Ball_colIndex`  in  4: ball column.
- `Ball_direction`  in  2: 00 UP_RIGHT, 01 UP_LEFT, 10 DOWN_RIGHT, 11 DOWN_LEFT.
  - UP means row−1; DOWN means row+1.
  - RIGHT means col−1; LEFT means col+1.
- `paddle_col`  in  4: leftmost (lowest-index) paddle cell in row 11.
- `new_level`  in  1: single-cycle pulse; reloads bricks from WIN.
- `data`  out  192: occupancy map; bit index = row*16+col; 1 = occupied.
- `score`  out  8: bricks cleared since reset; saturates at 255.
- `remaining`  out  8: bricks left in the current level.
- `lives`  out  2: lives left.
- `field_ready`  out  1: high only in PLAY; the top level holds the ball block in reset while this is low.
- `miss`  out  1: one-cycle pulse on each lost ball.
- `level_clear`  out  1: high in WIN.
- `game_over`  out  1: high in OVER.

## Operation
- **Map composition**
  - Rows 1..BRICK_ROWS come from brick registers.
  - Row 11 is the paddle. Bits paddle_col .. paddle_col+PADDLE_W−1 are set; cells beyond col 15 are dropped, not wrapped. This row is combinational from `paddle_col`.
  - All other rows are 0.
- **FSM states:** INIT, PLAY, MISS, WIN, OVER.
- **INIT**
  - Writes one brick row per cycle, all 16 bits = 1, using a row counter from 1 to BRICK_ROWS.
  - When the last row is written: `remaining` = 16*BRICK_ROWS, then go to PLAY.
- **PLAY, hit detection**
  - Evaluated every cycle on the current inputs.
  - Targets:
    - V = (row±1, col).
    - H = (row, col∓1).
    - D = (row±1, col∓1).
  - Neighbour coordinates are computed 5 bits wide. A target outside rows 1..BRICK_ROWS or cols 0..15 is never cleared.
  - If V or H holds a brick, clear every one of V and H that holds a brick; D is untouched.
  - Otherwise, if D holds a brick, clear D.
  - This priority matches the bounce rule in the ball block.
- **PLAY, counter update**
  - Let n = number of cells cleared this cycle (0..2).
  - `score` += n, saturating at 255.
  - `remaining` −= n.
  - Clearing takes effect at the same edge at which the ball block samples the old map. Both blocks therefore decide on identical data.
- **PLAY, exits** (priority WIN > MISS)
  - If `remaining` reaches 0 after the update, go to WIN.
  - Else if `Ball_rowIndex` == 11: pulse `miss` and decrement `lives`. Go to OVER if `lives` becomes 0, otherwise go to MISS.
- **MISS:** wait until `Ball_rowIndex` ≠ 11 (the top level re-seats the ball), then return to PLAY. No clearing in MISS.
- **WIN:** hold all state. On `new_level`, go to INIT. `score` and `lives` are kept.
- **OVER:** terminal; left only by `reset`.
- `new_level` is ignored in every state other than WIN.

## Timing
- **Reset values:**
  - State = INIT, row counter = 1.
  - Brick registers all 0.
  - `score` = 0, `remaining` = 0, `lives` = LIVES.
  - `miss`, `level_clear`, `game_over`, `field_ready` all 0.
- Level load takes BRICK_ROWS cycles. `field_ready` rises on the edge that enters PLAY.
- Brick clear latency: 1 cycle. The bit is 0 in `data` after the edge at which the neighbour condition was true.
- **Counters:** `score`, `remaining` and `lives` are registered and update at the same edge as the clear.
- `miss` is high for exactly the one cycle following the detection edge.
- Reset asserted mid-operation: everything returns to reset values immediately, and a fresh INIT starts on reset release.

## Structure
- **Package `bricks_pkg`:**
  - Grid constants: ROWS = 12, COLS = 16, PADDLE_ROW = 11.
  - Direction encoding: UP_RIGHT, UP_LEFT, DOWN_RIGHT, DOWN_LEFT.
  - FSM state enum.
- **Sub-module `brick_hit_detect`** (combinational):
  - Inputs: position, direction, brick map.
  - Outputs: a clear mask the width of the brick region, plus a 2-bit hit count n.
- **`brick_field` proper:** FSM, brick registers, counters, paddle row generation.

## Test plan
- Reset released, BRICK_ROWS = 4:
  - `field_ready` rises 4 cycles after release.
  - `data[79:16]` all 1, `remaining` = 64.
- PLAY, ball (5,7) UP_LEFT:
  - Bit 71 (4,7) cleared next cycle.
  - `score` = 1, `remaining` = 63, bit 70 untouched.
- Pre-clear (4,8), then ball (5,9) UP_RIGHT:
  - V (4,9) cleared; H (5,8) is empty; D (4,8) is also empty.
  - `score` +1.
- Clear (4,9) and (4,8), then ball (5,9) UP_RIGHT with (4,9) empty, (5,8) empty, D (4,8) re-set by reload:
  - Only bit 72 is cleared.
- Ball at (0,0) UP_RIGHT: no bit changes and counters are unchanged.
- Miss and game over:
  - `Ball_rowIndex` = 11 in PLAY: `miss` pulses once, `lives` 3→2, state MISS.
  - Row changes to 9: state returns to PLAY.
  - Third miss: `game_over` = 1.
- Level clear and reload:
  - Force `remaining` to 1 and hit the last brick: `level_clear` = 1.
  - `new_level`: INIT, then `remaining` = 64 with `score` preserved.
- `paddle_col` = 14, PADDLE_W = 4: only bits 190 and 191 are set in row 11.
